// File: rtl/pe_pkg.sv
// Shared PE definitions: filter-read sequencer states, default sizes, skid depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    localparam int DEF_MEM_DEPTH  = 224;
    localparam int DEF_DATA_WIDTH = 16;

    // Entries in the output skid buffer; the read credit rule is sized against this.
    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry skid FIFO; the head entry drives the output directly from flops.
// Latency: a push is visible at the head the cycle after it is written (when empty).
// Backpressure: pop and push may coincide; a push while full without a pop is an error.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push_i/push_dat_i write strobe and word
//   pop_i             remove head (ignored when empty)
//   head_dat_o        head word (registered)
//   head_vld_o        head holds a valid word (registered)
//   occ_o             current fill, 0..2
module skid_fifo2
    import pe_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             head_vld_o,
    output logic [1:0]       occ_o
);

    localparam logic [1:0] FULL = 2'(SKID_DEPTH);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;
    logic             vld_q;
    logic             pop;

    assign pop = pop_i && (occ_q != 2'd0);

    // Head/tail shift structure: the head is always the oldest word, so the
    // output never needs a read-pointer mux.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case (occ_q)
            2'd0: begin
                if (push_i) begin
                    head_d = push_dat_i;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (pop && push_i) begin
                    head_d = push_dat_i;
                end else if (pop) begin
                    occ_d = 2'd0;
                end else if (push_i) begin
                    tail_d = push_dat_i;
                    occ_d  = 2'd2;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = push_dat_i;
                    end else begin
                        occ_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
            vld_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            vld_q  <= (occ_d != 2'd0);
        end
    end

    assign head_dat_o = head_q;
    assign head_vld_o = vld_q;
    assign occ_o      = occ_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push_i && !pop && (occ_q == FULL)));

endmodule

// File: rtl/filter_spad_reader.sv
// Walks the filter scratchpad row once per sliding window and streams weights to the MAC.
// Latency: first w_valid two clocks after start is sampled; then 1 word/clk when unstalled.
// Backpressure: w_ready low holds the head word; reads are credited so the 2-entry skid never overflows.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start, row_len, num_passes  job launch; lengths sampled on start while idle
//   spad_empty                  spad has not yet written spad_r_addr
//   spad_r_en, spad_r_addr      spad read request
//   spad_dout                   spad read data, one clock after spad_r_en
//   w_data, w_valid, w_last     weight stream to MAC (w_last tags end of each pass)
//   w_ready                     MAC accepts when w_valid && w_ready
//   busy, done                  job in progress; one-cycle completion pulse
module filter_spad_reader
    import pe_pkg::*;
#(
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int PASS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] row_len,
    input  logic [PASS_WIDTH-1:0] num_passes,
    input  logic                  spad_empty,
    output logic                  spad_r_en,
    output logic [ADDR_WIDTH-1:0] spad_r_addr,
    input  logic [DATA_WIDTH-1:0] spad_dout,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic                  w_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [PASS_WIDTH-1:0] PASS_ONE = PASS_WIDTH'(1);
    localparam logic [1:0]            CREDITS  = 2'(SKID_DEPTH);

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] row_len_q, row_len_d;
    logic [PASS_WIDTH-1:0] pass_q, pass_d;
    logic [PASS_WIDTH-1:0] num_passes_q, num_passes_d;
    logic                  inflight_q;
    logic                  inflight_last_q;

    logic [DATA_WIDTH:0]   head_dat;
    logic                  head_vld;
    logic [1:0]            occ;
    logic [1:0]            occ_net;
    logic [1:0]            credit_used;
    logic                  pop;
    logic                  rd_en;
    logic                  last_addr;
    logic                  last_pass;

    assign pop = head_vld && w_ready;

    // Occupancy is taken net of this cycle's pop; without that, a buffered
    // head plus one in-flight read would stall every other cycle and the
    // stream could not reach one word per clock.
    assign occ_net     = occ - {1'b0, pop};
    assign credit_used = occ_net + {1'b0, inflight_q};

    assign last_addr = (addr_q == (row_len_q - ADDR_ONE));
    assign last_pass = (pass_q == (num_passes_q - PASS_ONE));
    assign rd_en     = (state_q == ST_RUN) && !spad_empty && (credit_used < CREDITS);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pass_d       = pass_q;
        row_len_d    = row_len_q;
        num_passes_d = num_passes_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    row_len_d    = row_len;
                    num_passes_d = num_passes;
                    addr_d       = '0;
                    pass_d       = '0;
                    if ((row_len == '0) || (num_passes == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (rd_en) begin
                    if (last_addr) begin
                        addr_d = '0;
                        if (last_pass) begin
                            state_d = ST_DRAIN;
                        end else begin
                            pass_d = pass_q + PASS_ONE;
                        end
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                // Final word has been accepted once nothing is buffered or in flight.
                if ((occ == 2'd0) && !inflight_q) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            pass_q          <= '0;
            row_len_q       <= '0;
            num_passes_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            pass_q          <= pass_d;
            row_len_q       <= row_len_d;
            num_passes_q    <= num_passes_d;
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en && last_addr;
        end
    end

    // A read issued on one edge returns on spad_dout during the next cycle
    // and is written into the skid on the following edge with its last tag.
    skid_fifo2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push_i     (inflight_q),
        .push_dat_i ({inflight_last_q, spad_dout}),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .head_vld_o (head_vld),
        .occ_o      (occ)
    );

    assign spad_r_en   = rd_en;
    assign spad_r_addr = addr_q;
    assign w_data      = head_dat[DATA_WIDTH-1:0];
    assign w_last      = head_dat[DATA_WIDTH];
    assign w_valid     = head_vld;
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);

    a_row_len_legal: assert property (@(posedge clk) disable iff (reset)
        ((state_q == ST_IDLE) && start) |-> (int'(row_len) <= MEM_DEPTH));

endmodule

// File: tb/tb_filter_spad_reader.sv
module tb_filter_spad_reader;

    localparam int MD = 224;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] row_len;
    logic [PW-1:0] num_passes;
    logic          spad_empty;
    logic          spad_r_en;
    logic [AW-1:0] spad_r_addr;
    logic [DW-1:0] spad_dout;
    logic [DW-1:0] w_data;
    logic          w_valid;
    logic          w_ready;
    logic          w_last;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int wr_cnt;

    logic [DW:0]   exp_q[$];
    logic [DW-1:0] mem [0:MD-1];

    filter_spad_reader #(
        .MEM_DEPTH (MD),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .PASS_WIDTH(PW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .row_len    (row_len),
        .num_passes (num_passes),
        .spad_empty (spad_empty),
        .spad_r_en  (spad_r_en),
        .spad_r_addr(spad_r_addr),
        .spad_dout  (spad_dout),
        .w_data     (w_data),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_last     (w_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Spad model: written-word count gates empty; one-clock registered read.
    assign spad_empty = (int'(spad_r_addr) >= wr_cnt);

    always @(posedge clk) begin
        if (spad_r_en) spad_dout <= mem[spad_r_addr];
    end

    task automatic pulse_start(input int rl, input int np);
        @(negedge clk);
        start      = 1'b1;
        row_len    = AW'(rl);
        num_passes = PW'(np);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_expected(input int rl, input int np);
        for (int p = 0; p < np; p++)
            for (int i = 0; i < rl; i++)
                exp_q.push_back({(i == rl - 1), DW'(i)});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({spad_r_en, spad_r_addr} !== '0) begin
            errors++;
            $display("FAIL reset_read: en/addr=%h required 0", {spad_r_en, spad_r_addr});
        end
        checks++;
        if ({w_valid, w_last, w_data} !== '0) begin
            errors++;
            $display("FAIL reset_stream: valid/last/data=%h required 0", {w_valid, w_last, w_data});
        end
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_status: busy/done=%b required 00", {busy, done});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one job at full rate and checks latency, order, tags and done timing.
    task automatic test_full_rate(input string name, input int rl, input int np);
        int first_vld, last_vld, done_cyc, nacc, nlast;
        logic [DW:0] e;
        first_vld = -1; last_vld = -1; done_cyc = -1; nacc = 0; nlast = 0;
        w_ready = 1'b1;
        wr_cnt  = MD;
        exp_q.delete();
        push_expected(rl, np);
        pulse_start(rl, np);
        for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
            #1;
            if (cyc == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_busy: busy=%b required 1", name, busy);
                end
            end
            if (w_valid && w_ready) begin
                if (first_vld < 0) first_vld = cyc;
                last_vld = cyc;
                nacc++;
                if (w_last) nlast++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_word: got %h with nothing expected", name, {w_last, w_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({w_last, w_data} !== e) begin
                        errors++;
                        $display("FAIL %s_word: got %h required %h", name, {w_last, w_data}, e);
                    end
                end
            end
            if (done) done_cyc = cyc;
            @(negedge clk);
        end
        #1;
        checks++;
        if (first_vld !== 2) begin
            errors++;
            $display("FAIL %s_first_valid: cycle %0d required 2", name, first_vld);
        end
        checks++;
        if (nacc !== rl * np || last_vld !== 2 + rl * np - 1) begin
            errors++;
            $display("FAIL %s_count: %0d words ending cycle %0d required %0d ending %0d",
                     name, nacc, last_vld, rl * np, 2 + rl * np - 1);
        end
        checks++;
        if (nlast !== np) begin
            errors++;
            $display("FAIL %s_last_tags: %0d required %0d", name, nlast, np);
        end
        checks++;
        if (done_cyc !== last_vld + 2) begin
            errors++;
            $display("FAIL %s_done_time: cycle %0d required %0d", name, done_cyc, last_vld + 2);
        end
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL %s_after_done: done/busy=%b required 00", name, {done, busy});
        end
    endtask

    task automatic test_backpressure();
        int nacc, issued, accepted, max_out, done_cyc;
        logic prev_stall;
        logic [DW:0] prev_word, e;
        nacc = 0; issued = 0; accepted = 0; max_out = 0; done_cyc = -1;
        prev_stall = 1'b0; prev_word = '0;
        wr_cnt = MD;
        exp_q.delete();
        push_expected(9, 2);
        w_ready = 1'b1;
        pulse_start(9, 2);
        for (int cyc = 0; cyc < 300 && done_cyc < 0; cyc++) begin
            w_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            #1;
            if (prev_stall) begin
                checks++;
                if (!w_valid || {w_last, w_data} !== prev_word) begin
                    errors++;
                    $display("FAIL bp_hold: valid=%b word=%h required 1 %h", w_valid, {w_last, w_data}, prev_word);
                end
            end
            prev_stall = w_valid && !w_ready;
            prev_word  = {w_last, w_data};
            if (spad_r_en) issued++;
            if (w_valid && w_ready) begin
                accepted++;
                nacc++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_word: got %h with nothing expected", {w_last, w_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({w_last, w_data} !== e) begin
                        errors++;
                        $display("FAIL bp_word: got %h required %h", {w_last, w_data}, e);
                    end
                end
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (done) done_cyc = cyc;
            @(negedge clk);
        end
        w_ready = 1'b1;
        checks++;
        if (nacc !== 18 || done_cyc < 0) begin
            errors++;
            $display("FAIL bp_complete: %0d words done_cycle %0d required 18 and done", nacc, done_cyc);
        end
        checks++;
        if (max_out > 2) begin
            errors++;
            $display("FAIL bp_occupancy: outstanding %0d required <= 2", max_out);
        end
    endtask

    task automatic test_concurrent_fill();
        int nacc, viol, stall_seen, done_cyc;
        logic [DW:0] e;
        nacc = 0; viol = 0; stall_seen = 0; done_cyc = -1;
        wr_cnt = 0;
        w_ready = 1'b1;
        exp_q.delete();
        push_expected(6, 1);
        pulse_start(6, 1);
        for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
            if ((cyc % 3) == 2 && wr_cnt < 6) wr_cnt++;
            #1;
            if (busy && spad_empty) stall_seen++;
            if (spad_empty && spad_r_en) viol++;
            if (w_valid && w_ready) begin
                nacc++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL fill_word: got %h with nothing expected", {w_last, w_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({w_last, w_data} !== e) begin
                        errors++;
                        $display("FAIL fill_word: got %h required %h", {w_last, w_data}, e);
                    end
                end
            end
            if (done) done_cyc = cyc;
            @(negedge clk);
        end
        wr_cnt = MD;
        checks++;
        if (viol !== 0 || stall_seen == 0) begin
            errors++;
            $display("FAIL fill_gate: reads while empty %0d stalls seen %0d required 0 and >0", viol, stall_seen);
        end
        checks++;
        if (nacc !== 6 || done_cyc < 0) begin
            errors++;
            $display("FAIL fill_complete: %0d words done_cycle %0d required 6 and done", nacc, done_cyc);
        end
    endtask

    task automatic test_zero_len();
        int rls[2] = '{0, 5};
        int nps[2] = '{3, 0};
        int done_cyc, ndone, bad;
        for (int k = 0; k < 2; k++) begin
            done_cyc = -1; ndone = 0; bad = 0;
            w_ready = 1'b1;
            pulse_start(rls[k], nps[k]);
            for (int cyc = 0; cyc < 6; cyc++) begin
                #1;
                if (done) begin
                    ndone++;
                    if (done_cyc < 0) done_cyc = cyc;
                end
                if (w_valid || spad_r_en || busy) bad++;
                @(negedge clk);
            end
            checks++;
            if (done_cyc !== 0 || ndone !== 1) begin
                errors++;
                $display("FAIL zero_done_%0d: first cycle %0d pulses %0d required 0 and 1", k, done_cyc, ndone);
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL zero_quiet_%0d: %0d active cycles required 0", k, bad);
            end
        end
    endtask

    task automatic test_reset_mid_job();
        int nacc, nlast, first_vld, done_cyc;
        logic [DW:0] e;
        nacc = 0;
        wr_cnt = MD;
        w_ready = 1'b1;
        exp_q.delete();
        push_expected(9, 2);
        pulse_start(9, 2);
        for (int cyc = 0; cyc < 100 && nacc < 13; cyc++) begin
            #1;
            if (w_valid && w_ready) begin
                nacc++;
                e = exp_q.pop_front();
                checks++;
                if ({w_last, w_data} !== e) begin
                    errors++;
                    $display("FAIL rst_pre_word: got %h required %h", {w_last, w_data}, e);
                end
            end
            if (nacc < 13) @(negedge clk);
        end
        checks++;
        if (nacc !== 13) begin
            errors++;
            $display("FAIL rst_reach: %0d words required 13", nacc);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({spad_r_en, spad_r_addr, w_valid, w_last, w_data, busy, done} !== '0) begin
            errors++;
            $display("FAIL rst_outputs: %h required 0",
                     {spad_r_en, spad_r_addr, w_valid, w_last, w_data, busy, done});
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        push_expected(9, 1);
        nacc = 0; nlast = 0; first_vld = -1; done_cyc = -1;
        pulse_start(9, 1);
        for (int cyc = 0; cyc < 100 && done_cyc < 0; cyc++) begin
            if (cyc == 2) begin
                start = 1'b1; row_len = AW'(3); num_passes = PW'(1);
            end else begin
                start = 1'b0;
            end
            #1;
            if (w_valid && w_ready) begin
                if (first_vld < 0) first_vld = cyc;
                nacc++;
                if (w_last) nlast++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rst_replay_word: got %h with nothing expected", {w_last, w_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({w_last, w_data} !== e) begin
                        errors++;
                        $display("FAIL rst_replay_word: got %h required %h", {w_last, w_data}, e);
                    end
                end
            end
            if (done) done_cyc = cyc;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (first_vld !== 2 || nacc !== 9 || nlast !== 1 || done_cyc < 0) begin
            errors++;
            $display("FAIL rst_replay: first %0d words %0d lasts %0d done_cycle %0d required 2 9 1 and done",
                     first_vld, nacc, nlast, done_cyc);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, w_valid, spad_r_en} !== 3'b000) begin
            errors++;
            $display("FAIL rst_idle: busy/valid/r_en=%b required 000", {busy, w_valid, spad_r_en});
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        row_len    = '0;
        num_passes = '0;
        w_ready    = 1'b0;
        wr_cnt     = MD;
        for (int i = 0; i < MD; i++) mem[i] = DW'(i);

        test_reset();
        test_full_rate("single", 9, 1);
        test_full_rate("multi", 9, 3);
        test_backpressure();
        test_concurrent_fill();
        test_zero_len();
        test_reset_mid_job();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
